// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves carries and sums.

module cla_grp_pg #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] p,
    input  logic [BLK-1:0] g,
    output logic           gp,
    output logic           gg
);
    // AND of v[hi:lo]; empty range yields 1
    function automatic logic span(input logic [BLK-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int j = 0; j < BLK; j++)
            if (j >= lo && j <= hi) r = r & v[j];
        return r;
    endfunction

    always_comb begin
        gp = &p;
        gg = 1'b0;
        for (int i = 0; i < BLK; i++)
            gg = gg | (g[i] & span(p, i + 1, BLK - 1));
    end
endmodule

module cla_grp_sum #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] p,
    input  logic [BLK-1:0] g,
    input  logic           ci,
    output logic [BLK-1:0] s
);
    function automatic logic span(input logic [BLK-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int j = 0; j < BLK; j++)
            if (j >= lo && j <= hi) r = r & v[j];
        return r;
    endfunction

    logic cb;

    // each bit carry is a flat sum of products from the group carry-in
    always_comb begin
        s  = '0;
        cb = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            cb = ci & span(p, 0, i - 1);
            for (int j = 0; j < BLK; j++)
                if (j < i) cb = cb | (g[j] & span(p, j + 1, i - 1));
            s[i] = p[i] ^ cb;
        end
    end
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NGRP   = WIDTH / BLK;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gg;
        logic             c0;
        logic             pmsb;
    } s1_t;

    logic [WIDTH-1:0]  bx, p0, g0, s2_sum;
    logic [NGRP-1:0]   gp0, gg0;
    logic [NGRP:0]     c;
    logic              cr;
    logic [STAGES:1]   vld_pipe;
    logic              adv1, adv2;
    s1_t               s1;

    assign bx = sub ? ~b : b;
    assign p0 = a ^ bx;
    assign g0 = a & bx;

    assign adv2      = !vld_pipe[2] | out_ready;
    assign adv1      = !vld_pipe[1] | adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_grp_pg #(.BLK(BLK)) u_pg (
            .p  (p0[k*BLK +: BLK]),
            .g  (g0[k*BLK +: BLK]),
            .gp (gp0[k]),
            .gg (gg0[k])
        );
        cla_grp_sum #(.BLK(BLK)) u_sum (
            .p  (s1.p[k*BLK +: BLK]),
            .g  (s1.g[k*BLK +: BLK]),
            .ci (c[k]),
            .s  (s2_sum[k*BLK +: BLK])
        );
    end

    // group carry chain; cr keeps the chain out of a self-referencing vector
    always_comb begin
        c  = '0;
        cr = s1.c0;
        for (int k = 0; k < NGRP; k++) begin
            c[k] = cr;
            cr   = s1.gg[k] | (s1.gp[k] & cr);
        end
        c[NGRP] = cr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid)
                    s1 <= '{p: p0, g: g0, gp: gp0, gg: gg0, c0: sub | cin, pmsb: p0[WIDTH-1]};
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    sum  <= s2_sum;
                    cout <= c[NGRP];
                    // carry into the MSB recovered as sum_msb ^ p_msb
                    ovf  <= s2_sum[WIDTH-1] ^ s1.pmsb ^ c[NGRP];
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: 16/4 instance for flow control and arithmetic, 8/2 for the wide-carry case.

module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    cla_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(8), .BLK(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    int          checks = 0, failures = 0, cyc = 0, idx;
    logic        acc = 1'b0;
    logic [17:0] outq[$];
    int          outc[$], accc[$];

    // stream vectors: {cout,ovf,sum} expectations worked by hand
    logic [15:0] va[8] = '{16'h1234, 16'hFFFF, 16'h5555, 16'h4000, 16'h0005, 16'h0007, 16'h8000, 16'h00FF};
    logic [15:0] vb[8] = '{16'h1111, 16'hFFFF, 16'hAAAA, 16'h4000, 16'h0007, 16'h0005, 16'h8000, 16'h0F01};
    logic        vc[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        vs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [17:0] ve[8] = '{18'h02345, 18'h2FFFF, 18'h0FFFF, 18'h18000,
                           18'h0FFFE, 18'h20002, 18'h30001, 18'h01001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // observe handshakes mid-cycle, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (acc) accc.push_back(cyc);
        if (out_valid && out_ready && !rst) begin
            outq.push_back({cout, ovf, sum});
            outc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic beat1(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input logic [17:0] exp);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk(tag, {cout, ovf, sum}, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        tick(); tick();
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_out", {cout, ovf, sum}, 18'h0);
        chk("rst_rdy", in_ready, 1'b1);

        // a beat offered during reset must not be captured
        in_valid = 1'b1; a = 16'h0005; b = 16'h0005;
        tick();
        in_valid = 1'b0; rst = 1'b0;
        tick(); tick();
        chk("rst_nocap", out_valid, 1'b0);

        beat1("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h20000);
        beat1("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h18000);
        beat1("subovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF);
        beat1("chain16", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 18'h01000);
        tick();
        chk("drain", out_valid, 1'b0);

        // backpressure: only two beats fit
        outq.delete();
        out_ready = 1'b0; idx = 0;
        for (int n = 0; n < 4; n++) begin
            a = 16'(idx + 1); b = 16'(idx + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
            if (acc) idx++;
        end
        chk("stall_acc", idx, 2);
        chk("stall_rdy", in_ready, 1'b0);
        chk("stall_vld", out_valid, 1'b1);
        chk("stall_sum", sum, 16'h0002);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && idx < 4; n++) begin
            a = 16'(idx + 1); b = 16'(idx + 1);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        for (int n = 0; n < 20 && outq.size() < 4; n++) tick();
        chk("stall_n", outq.size(), 4);
        for (int i = 0; i < 4 && i < outq.size(); i++)
            chk("stall_out", outq[i], {2'b00, 16'(2 * (i + 1))});

        // back-to-back stream
        outq.delete(); outc.delete(); accc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            tick();
            chk("strm_acc", acc, 1'b1);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 20 && outq.size() < 8; n++) tick();
        chk("strm_n", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size() && i < accc.size(); i++) begin
            chk("strm_data", outq[i], ve[i]);
            chk("strm_lat", outc[i] - accc[i], 2);
        end

        // reset with two beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 16'(i + 1); b = 16'(i + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstf_vld", out_valid, 1'b0);
        chk("rstf_sum", sum, 16'h0000);
        chk("rstf_rdy", in_ready, 1'b1);
        tick();
        chk("rstf_stale", out_valid, 1'b0);
        beat1("rstf_beat", 16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345);

        // 8-bit / 2-bit-group instance
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
        tick();
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        chk("w8_vld", out_valid8, 1'b1);
        chk("w8_chain", {cout8, ovf8, sum8}, 10'h200);
        tick();
        chk("w8_vld2", out_valid8, 1'b1);
        chk("w8_sub", {cout8, ovf8, sum8}, 10'h0F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
